// File: rtl/controlador_contador16_pkg.sv
// Shared encodings for the cascaded-counter sequencer: counter modes and FSM states.
package controlador_contador16_pkg;

  localparam logic [1:0] MODO_SUMA1  = 2'b00;
  localparam logic [1:0] MODO_RESTA1 = 2'b01;
  localparam logic [1:0] MODO_SUMA3  = 2'b10;
  localparam logic [1:0] MODO_CARGA  = 2'b11;

  localparam int NUM_SOLICITANTES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CARGA  = 2'd1,
    CUENTA = 2'd2,
    FIN    = 2'd3
  } estado_t;

  // A job skips counting when it only loads, or when zero count cycles were requested.
  function automatic logic sin_cuenta(input logic [1:0] modo, input logic ciclos_cero);
    return (modo == MODO_CARGA) || ciclos_cero;
  endfunction

endpackage

// File: rtl/controlador_contador16_arbitro_rr2.sv
// Two-requester round-robin arbiter: the pointer decides ties, then moves to the loser.
module controlador_contador16_arbitro_rr2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       habilitar,
  input  logic [1:0] elegible,
  output logic       concede,
  output logic       id_concedido
);

  logic puntero_reg;

  always_comb begin
    concede      = 1'b0;
    id_concedido = 1'b0;
    if (habilitar) begin
      case (elegible)
        2'b01: begin
          concede      = 1'b1;
          id_concedido = 1'b0;
        end
        2'b10: begin
          concede      = 1'b1;
          id_concedido = 1'b1;
        end
        2'b11: begin
          concede      = 1'b1;
          id_concedido = puntero_reg;
        end
        default: begin
          concede      = 1'b0;
          id_concedido = 1'b0;
        end
      endcase
    end
  end

  // The pointer only moves when both requesters actually competed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      puntero_reg <= 1'b0;
    end else if (habilitar && (elegible == 2'b11)) begin
      puntero_reg <= ~puntero_reg;
    end
  end

endmodule

// File: rtl/controlador_contador16.sv
// Job sequencer for the 16-bit cascaded counter: arbitrates two requesters, loads,
// counts N cycles and returns the final Q together with an RCO-seen flag.
module controlador_contador16 #(
  parameter int ANCHO        = 16,
  parameter int ANCHO_CICLOS = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    REQ0,
  input  logic                    REQ1,
  input  logic [1:0]              MODO0,
  input  logic [1:0]              MODO1,
  input  logic [ANCHO-1:0]        DATO0,
  input  logic [ANCHO-1:0]        DATO1,
  input  logic [ANCHO_CICLOS-1:0] CICLOS0,
  input  logic [ANCHO_CICLOS-1:0] CICLOS1,
  output logic                    ACK0,
  output logic                    ACK1,
  output logic [ANCHO-1:0]        RESULTADO,
  output logic                    DESBORDE,
  output logic                    OCUPADO,
  output logic                    CNT_ENB,
  output logic [1:0]              CNT_MODO,
  output logic [ANCHO-1:0]        CNT_D,
  input  logic [ANCHO-1:0]        CNT_Q,
  input  logic                    CNT_RCO
);

  import controlador_contador16_pkg::*;

  logic [1:0]              req_vec;
  logic [1:0]              ack_reg;
  logic [1:0]              elegible;
  logic [1:0]              modo_vec   [NUM_SOLICITANTES];
  logic [ANCHO-1:0]        dato_vec   [NUM_SOLICITANTES];
  logic [ANCHO_CICLOS-1:0] ciclos_vec [NUM_SOLICITANTES];

  logic                    concede;
  logic                    id_concedido;

  estado_t                 estado_reg;
  logic [1:0]              modo_lat_reg;
  logic [ANCHO-1:0]        dato_lat_reg;
  logic [ANCHO_CICLOS-1:0] ciclos_lat_reg;
  logic                    id_lat_reg;
  logic [ANCHO_CICLOS-1:0] restante_reg;
  logic                    desborde_flag_reg;

  logic [ANCHO-1:0]        resultado_reg;
  logic                    desborde_reg;
  logic                    ocupado_reg;
  logic                    cnt_enb_reg;
  logic [1:0]              cnt_modo_reg;
  logic [ANCHO-1:0]        cnt_d_reg;

  assign req_vec       = {REQ1, REQ0};
  assign modo_vec[0]   = MODO0;
  assign modo_vec[1]   = MODO1;
  assign dato_vec[0]   = DATO0;
  assign dato_vec[1]   = DATO1;
  assign ciclos_vec[0] = CICLOS0;
  assign ciclos_vec[1] = CICLOS1;

  // A requester is ignored in the cycle its own ACK is high, so a held REQ is not re-served.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SOLICITANTES; gi++) begin : g_elegible
      assign elegible[gi] = req_vec[gi] & ~ack_reg[gi];
    end
  endgenerate

  controlador_contador16_arbitro_rr2 u_arbitro (
    .clk          (CLK),
    .rst          (RESET),
    .habilitar    (estado_reg == IDLE),
    .elegible     (elegible),
    .concede      (concede),
    .id_concedido (id_concedido)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      estado_reg        <= IDLE;
      modo_lat_reg      <= MODO_SUMA1;
      dato_lat_reg      <= '0;
      ciclos_lat_reg    <= '0;
      id_lat_reg        <= 1'b0;
      restante_reg      <= '0;
      desborde_flag_reg <= 1'b0;
      ack_reg           <= '0;
      resultado_reg     <= '0;
      desborde_reg      <= 1'b0;
      ocupado_reg       <= 1'b0;
      cnt_enb_reg       <= 1'b0;
      cnt_modo_reg      <= MODO_SUMA1;
      cnt_d_reg         <= '0;
    end else begin
      ack_reg <= '0;
      case (estado_reg)
        IDLE: begin
          if (concede) begin
            modo_lat_reg   <= modo_vec[id_concedido];
            dato_lat_reg   <= dato_vec[id_concedido];
            ciclos_lat_reg <= ciclos_vec[id_concedido];
            id_lat_reg     <= id_concedido;
            cnt_enb_reg    <= 1'b1;
            cnt_modo_reg   <= MODO_CARGA;
            cnt_d_reg      <= dato_vec[id_concedido];
            ocupado_reg    <= 1'b1;
            estado_reg     <= CARGA;
          end
        end
        CARGA: begin
          desborde_flag_reg <= 1'b0;
          restante_reg      <= ciclos_lat_reg;
          cnt_d_reg         <= '0;
          if (sin_cuenta(modo_lat_reg, ciclos_lat_reg == '0)) begin
            cnt_enb_reg  <= 1'b0;
            cnt_modo_reg <= MODO_SUMA1;
            estado_reg   <= FIN;
          end else begin
            cnt_modo_reg <= modo_lat_reg;
            estado_reg   <= CUENTA;
          end
        end
        CUENTA: begin
          if (CNT_RCO) begin
            desborde_flag_reg <= 1'b1;
          end
          restante_reg <= restante_reg - 1'b1;
          if (restante_reg == ANCHO_CICLOS'(1)) begin
            cnt_enb_reg  <= 1'b0;
            cnt_modo_reg <= MODO_SUMA1;
            estado_reg   <= FIN;
          end
        end
        FIN: begin
          resultado_reg       <= CNT_Q;
          desborde_reg        <= desborde_flag_reg;
          ack_reg[id_lat_reg] <= 1'b1;
          ocupado_reg         <= 1'b0;
          estado_reg          <= IDLE;
        end
        default: begin
          estado_reg <= IDLE;
        end
      endcase
    end
  end

  assign ACK0      = ack_reg[0];
  assign ACK1      = ack_reg[1];
  assign RESULTADO = resultado_reg;
  assign DESBORDE  = desborde_reg;
  assign OCUPADO   = ocupado_reg;
  assign CNT_ENB   = cnt_enb_reg;
  assign CNT_MODO  = cnt_modo_reg;
  assign CNT_D     = cnt_d_reg;

endmodule

// File: tb/tb_controlador_contador16.sv
// Bench for controlador_contador16: behavioural counter on the CNT_* side plus an arithmetic job model.
module tb_controlador_contador16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  modo   [2];
  logic [15:0] dato   [2];
  logic [7:0]  ciclos [2];
  logic [1:0]  ack;
  logic [15:0] resultado;
  logic        desborde, ocupado, cnt_enb, rco;
  logic [1:0]  cnt_modo;
  logic [15:0] cnt_d;
  logic [15:0] q_cnt = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  controlador_contador16 dut (
    .CLK(clk), .RESET(rst),
    .REQ0(req[0]), .REQ1(req[1]),
    .MODO0(modo[0]), .MODO1(modo[1]),
    .DATO0(dato[0]), .DATO1(dato[1]),
    .CICLOS0(ciclos[0]), .CICLOS1(ciclos[1]),
    .ACK0(ack[0]), .ACK1(ack[1]),
    .RESULTADO(resultado), .DESBORDE(desborde), .OCUPADO(ocupado),
    .CNT_ENB(cnt_enb), .CNT_MODO(cnt_modo), .CNT_D(cnt_d),
    .CNT_Q(q_cnt), .CNT_RCO(rco)
  );

  // External 16-bit counter; RCO flags that the step now being taken wraps past 2^16.
  always @(posedge clk) begin
    if (cnt_enb) begin
      case (cnt_modo)
        2'b00:   q_cnt <= q_cnt + 16'd1;
        2'b01:   q_cnt <= q_cnt - 16'd1;
        2'b10:   q_cnt <= q_cnt + 16'd3;
        default: q_cnt <= cnt_d;
      endcase
    end
  end
  assign rco = cnt_enb && (((cnt_modo == 2'b00) && (q_cnt == 16'hFFFF)) ||
                           ((cnt_modo == 2'b01) && (q_cnt == 16'h0000)) ||
                           ((cnt_modo == 2'b10) && (q_cnt >= 16'hFFFD)));

  function automatic logic [16:0] ref_job(input logic [1:0] m, input logic [15:0] d, input int n);
    int   v;
    logic o;
    v = int'(d);
    o = 1'b0;
    if (m != 2'b11) begin
      for (int i = 0; i < n; i++) begin
        if (m == 2'b00) v = v + 1;
        else if (m == 2'b01) v = v - 1;
        else v = v + 3;
        if (v > 65535) begin v = v - 65536; o = 1'b1; end
        else if (v < 0) begin v = v + 65536; o = 1'b1; end
      end
    end
    return {o, v[15:0]};
  endfunction

  function automatic int ref_lat(input logic [1:0] m, input int n);
    return ((m == 2'b11) || (n == 0)) ? 3 : n + 3;
  endfunction

  // Raises one request, waits for its ACK (bounded) and reports what was seen.
  task automatic run_job(input int id, input logic [1:0] m, input logic [15:0] d, input int n,
                         output int lat, output logic [15:0] res, output logic ovf,
                         output int oth, output logic busy);
    lat = -1; res = 'x; ovf = 1'bx; oth = 0; busy = 1'bx;
    @(posedge clk); #1;
    modo[id] = m; dato[id] = d; ciclos[id] = 8'(n); req[id] = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (ack[1-id]) oth++;
      if (ack[id]) begin
        lat = k; res = resultado; ovf = desborde; busy = ocupado;
        break;
      end
    end
    req[id] = 1'b0;
    $display("job port=%0d modo=%0d dato=%h n=%0d -> lat=%0d res=%h ovf=%b", id, m, d, n, lat, res, ovf);
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({ack, resultado, desborde, ocupado, cnt_enb, cnt_modo, cnt_d} !== 39'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 0", {ack, resultado, desborde, ocupado, cnt_enb, cnt_modo, cnt_d});
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({ocupado, cnt_enb, ack} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_idle: got %b required 0000", {ocupado, cnt_enb, ack});
    end
  endtask

  task automatic test_single_up;
    int lat, oth; logic [15:0] res; logic ovf, busy;
    run_job(0, 2'b00, 16'h0010, 5, lat, res, ovf, oth, busy);
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL single_up_lat: got %0d required 8", lat); end
    n_cmp++; if (res !== 16'h0015) begin n_err++; $display("FAIL single_up_res: got %h required 0015", res); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL single_up_ovf: got %b required 0", ovf); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_up_busy_at_ack: got %b required 0", busy); end
    @(posedge clk); #1;
    n_cmp++; if (ack !== 2'b00) begin n_err++; $display("FAIL single_up_ack_width: got %b required 00", ack); end
    n_cmp++; if (resultado !== 16'h0015) begin n_err++; $display("FAIL single_up_hold: got %h required 0015", resultado); end
  endtask

  task automatic test_overflow;
    int lat, oth; logic [15:0] res; logic ovf, busy;
    run_job(1, 2'b10, 16'hFFFD, 2, lat, res, ovf, oth, busy);
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL overflow_lat: got %0d required 5", lat); end
    n_cmp++; if (res !== 16'h0003) begin n_err++; $display("FAIL overflow_res: got %h required 0003", res); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL overflow_flag: got %b required 1", ovf); end
    n_cmp++; if (oth !== 0) begin n_err++; $display("FAIL overflow_ack0: got %0d required 0", oth); end
  endtask

  task automatic test_load_only;
    int lat, oth; logic [15:0] res, d; logic ovf, busy;
    run_job(0, 2'b11, 16'hA5A5, 9, lat, res, ovf, oth, busy);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL load_only_lat: got %0d required 3", lat); end
    n_cmp++; if (res !== 16'hA5A5) begin n_err++; $display("FAIL load_only_res: got %h required a5a5", res); end
    d = 16'($urandom);
    run_job(0, 2'b01, d, 0, lat, res, ovf, oth, busy);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL zero_len_lat: got %0d required 3", lat); end
    n_cmp++; if (res !== d) begin n_err++; $display("FAIL zero_len_res: got %h required %h", res, d); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL zero_len_ovf: got %b required 0", ovf); end
  endtask

  task automatic test_contention;
    logic [1:0]  jm [3];
    logic [15:0] jd [3];
    int          jn [3];
    int          order [$];
    int          cyc [$];
    logic [16:0] got [$];
    logic        reraise;
    int          exp_cyc;
    logic [16:0] e;
    for (int j = 0; j < 3; j++) begin
      jm[j] = 2'($urandom_range(0, 2)); jd[j] = 16'($urandom); jn[j] = $urandom_range(1, 8);
    end
    reraise = 1'b0;
    @(posedge clk); #1;
    modo[0] = jm[0]; dato[0] = jd[0]; ciclos[0] = 8'(jn[0]);
    modo[1] = jm[1]; dato[1] = jd[1]; ciclos[1] = 8'(jn[1]);
    req = 2'b11;
    for (int k = 1; k <= 200 && order.size() < 3; k++) begin
      @(posedge clk); #1;
      if (reraise) begin
        modo[0] = jm[2]; dato[0] = jd[2]; ciclos[0] = 8'(jn[2]); req[0] = 1'b1; reraise = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (ack[i]) begin
          order.push_back(i); cyc.push_back(k); got.push_back({desborde, resultado});
          req[i] = 1'b0;
          if (i == 0 && order.size() == 1) reraise = 1'b1;
        end
      end
    end
    req = 2'b00;
    n_cmp++;
    if (order.size() != 3) begin
      n_err++; $display("FAIL contention_count: got %0d acks required 3", order.size());
    end else begin
      exp_cyc = 0;
      for (int j = 0; j < 3; j++) begin
        e = ref_job(jm[j], jd[j], jn[j]);
        exp_cyc = exp_cyc + ref_lat(jm[j], jn[j]);
        $display("contention grant %0d: port=%0d cycle=%0d res=%h ovf=%b", j, order[j], cyc[j], got[j][15:0], got[j][16]);
        n_cmp++; if (order[j] !== (j % 2)) begin n_err++; $display("FAIL contention_order%0d: got %0d required %0d", j, order[j], j % 2); end
        n_cmp++; if (got[j] !== e) begin n_err++; $display("FAIL contention_res%0d: got %h required %h", j, got[j], e); end
        n_cmp++; if (cyc[j] !== exp_cyc) begin n_err++; $display("FAIL contention_cycle%0d: got %0d required %0d", j, cyc[j], exp_cyc); end
      end
    end
  endtask

  task automatic test_alternation;
    int         first;
    logic [1:0] seen;
    for (int r = 0; r < 2; r++) begin
      first = -1; seen = 2'b00;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        modo[i] = 2'($urandom_range(0, 2)); dato[i] = 16'($urandom); ciclos[i] = 8'($urandom_range(1, 4));
      end
      req = 2'b11;
      for (int k = 0; k < 100 && seen != 2'b11; k++) begin
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
          if (ack[i]) begin
            if (first < 0) first = i;
            seen[i] = 1'b1; req[i] = 1'b0;
          end
        end
      end
      req = 2'b00;
      $display("alternation round %0d: first port=%0d", r, first);
      n_cmp++; if (seen !== 2'b11) begin n_err++; $display("FAIL alternation_done%0d: got %b required 11", r, seen); end
      n_cmp++; if (first !== 1 - r) begin n_err++; $display("FAIL alternation_first%0d: got %0d required %0d", r, first, 1 - r); end
    end
  endtask

  task automatic test_inputs_after_grant;
    int acks, first; logic [15:0] res; logic ovf;
    acks = 0; first = -1; res = 'x; ovf = 1'bx;
    @(posedge clk); #1;
    modo[0] = 2'b00; dato[0] = 16'h1234; ciclos[0] = 8'd6; req[0] = 1'b1;
    @(posedge clk); #1;
    modo[0] = 2'b10; dato[0] = 16'hBEEF; ciclos[0] = 8'd1; req[0] = 1'b0;
    for (int k = 2; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ack[0]) begin
        acks++;
        if (first < 0) begin first = k; res = resultado; ovf = desborde; end
      end
    end
    $display("after_grant: acks=%0d cycle=%0d res=%h ovf=%b", acks, first, res, ovf);
    n_cmp++; if (acks !== 1) begin n_err++; $display("FAIL after_grant_acks: got %0d required 1", acks); end
    n_cmp++; if (first !== 9) begin n_err++; $display("FAIL after_grant_lat: got %0d required 9", first); end
    n_cmp++; if ({ovf, res} !== 17'h0123A) begin n_err++; $display("FAIL after_grant_res: got %h required 0123a", {ovf, res}); end
  endtask

  task automatic test_random;
    int id, n, lat, oth; logic [1:0] m; logic [15:0] d, res; logic ovf, busy; logic [16:0] e;
    for (int t = 0; t < 25; t++) begin
      id = $urandom_range(0, 1);
      m  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       d = 16'hFFFF - 16'($urandom_range(0, 3));
        1:       d = 16'($urandom_range(0, 3));
        default: d = 16'($urandom);
      endcase
      n = (t == 24) ? 255 : $urandom_range(0, 12);
      if (t == 24) begin m = 2'b01; d = 16'h0080; end
      run_job(id, m, d, n, lat, res, ovf, oth, busy);
      e = ref_job(m, d, n);
      n_cmp++; if ({ovf, res} !== e) begin n_err++; $display("FAIL random%0d_res: got %h required %h", t, {ovf, res}, e); end
      n_cmp++; if (lat !== ref_lat(m, n)) begin n_err++; $display("FAIL random%0d_lat: got %0d required %0d", t, lat, ref_lat(m, n)); end
      n_cmp++; if (oth !== 0) begin n_err++; $display("FAIL random%0d_other_ack: got %0d required 0", t, oth); end
    end
  endtask

  task automatic test_reset_mid_job;
    int acks, lat, oth; logic [15:0] res; logic ovf, busy;
    @(posedge clk); #1;
    modo[0] = 2'b00; dato[0] = 16'h1000; ciclos[0] = 8'd20; req[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++;
    if ({ocupado, cnt_enb, cnt_modo} !== 4'b1100) begin
      n_err++; $display("FAIL midjob_counting: got %b required 1100", {ocupado, cnt_enb, cnt_modo});
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({ack, resultado, desborde, ocupado, cnt_enb, cnt_modo, cnt_d} !== 39'd0) begin
      n_err++;
      $display("FAIL midjob_reset_outputs: got %h required 0", {ack, resultado, desborde, ocupado, cnt_enb, cnt_modo, cnt_d});
    end
    req[0] = 1'b0;
    #2 rst = 1'b0;
    acks = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (ack != 2'b00) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_err++; $display("FAIL midjob_no_ack: got %0d required 0", acks); end
    run_job(0, 2'b00, 16'h7FFE, 4, lat, res, ovf, oth, busy);
    n_cmp++; if (lat !== 7) begin n_err++; $display("FAIL post_reset_lat: got %0d required 7", lat); end
    n_cmp++; if ({ovf, res} !== 17'h08002) begin n_err++; $display("FAIL post_reset_res: got %h required 08002", {ovf, res}); end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      modo[i] = 2'b00; dato[i] = '0; ciclos[i] = '0;
    end
    test_reset();
    test_single_up();
    test_overflow();
    test_load_only();
    test_contention();
    test_alternation();
    test_inputs_after_grant();
    test_random();
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
